// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state encoding and one-hot helper for the scan decoder
package decoder_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIRECT = 2'd1, S_SCAN = 2'd2} state_t;
  localparam int IDX_MAX_W = 8;
  function automatic logic [2**IDX_MAX_W-1:0] onehot(input logic [IDX_MAX_W-1:0] idx);
    return (2**IDX_MAX_W)'(1) << idx;
  endfunction
endpackage

// File: rtl/decoder_scan_n_dwell.sv
// dwell_counter: counts cycles spent on a scan position and flags when to advance
module dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               clka,
  input  logic               rst_n,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               clear,
  input  logic               run,
  output logic               expire
);
  logic [DWELL_W-1:0] cnt;
  assign expire = run && !clear && cnt >= dwell;
  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear || expire) cnt <= '0;
    else if (run) cnt <= cnt + 1'b1;
endmodule

// File: rtl/decoder_scan_n.sv
// decoder_scan_n: registered index-to-one-hot decoder with programmable auto-scan
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter  int IN_W    = 3,
  parameter  int DWELL_W = 4,
  localparam int OUT_W   = 2**IN_W
) (
  input  logic               clka,
  input  logic               rst_n,
  input  logic               E,
  input  logic               Mode,
  input  logic [IN_W-1:0]    In,
  input  logic               Load,
  input  logic [DWELL_W-1:0] Dwell,
  output logic [OUT_W-1:0]   Out,
  output logic [IN_W-1:0]    Idx,
  output logic               Wrap
);
  state_t state, nxt;
  logic expire, clear;
  logic [IN_W-1:0] idx_next;
  assign nxt = !E ? S_IDLE : Mode ? S_SCAN : S_DIRECT;
  assign clear = Load || nxt == S_DIRECT;
  assign idx_next = clear ? In : Idx + IN_W'(expire);
  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clka(clka), .rst_n(rst_n), .dwell(Dwell), .clear(clear),
    .run(nxt == S_SCAN), .expire(expire)
  );
  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      Idx   <= '0;
      Out   <= '0;
      Wrap  <= 1'b0;
    end else begin
      state <= nxt;
      Idx   <= idx_next;
      Out   <= nxt == S_IDLE ? '0 : OUT_W'(onehot(IDX_MAX_W'(idx_next)));
      Wrap  <= expire && Idx == '1;
    end
  // Out must be dark while idle and strictly one-hot otherwise
  always_ff @(posedge clka)
    if (rst_n) assert (state == S_IDLE ? Out == '0 : $onehot(Out));
endmodule
